// File: rtl/multi_buffer_ctrl_pkg.sv
// Shared types and helpers for the multi-buffer swap controller.
package multi_buffer_pkg;

   // Largest supported number of frame RAMs.
   localparam int unsigned MAX_BUF = 4;

   // WAIT is only entered in the two-buffer build (writer has no spare buffer).
   typedef enum logic {
      StWrite = 1'b0,
      StWait  = 1'b1
   } state_e;

   // One-hot decode of a buffer index; callers truncate to their buffer count.
   function automatic logic [MAX_BUF-1:0] onehot(input logic [31:0] idx);
      logic [MAX_BUF-1:0] res;
      res = '0;
      for (int unsigned i = 0; i < MAX_BUF; i++) begin
         res[i] = (idx == i);
      end
      return res;
   endfunction

endpackage

// File: rtl/multi_buffer_ctrl_if.sv
// Renderer/reader-side bundle of the multi-buffer swap controller.
// master: renderer + VGA timing side; slave: the controller.
interface multi_buffer_ctrl_if #(
   parameter int unsigned NUM_BUF = 2,
   parameter int unsigned Y_W     = 8
);
   localparam int unsigned IDX_W = $clog2(NUM_BUF);

   logic [Y_W-1:0]     y;
   logic               wr_valid;
   logic               wr_done;
   logic               frame_sync;
   logic [NUM_BUF-1:0] wr_en;
   logic [NUM_BUF-1:0] rd_en;
   logic [Y_W-1:0]     wr_y;
   logic               wr_stall;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;

   modport master (
      output y, wr_valid, wr_done, frame_sync,
      input  wr_en, rd_en, wr_y, wr_stall, wr_idx, rd_idx
   );

   modport slave (
      input  y, wr_valid, wr_done, frame_sync,
      output wr_en, rd_en, wr_y, wr_stall, wr_idx, rd_idx
   );

endinterface

// File: rtl/multi_buffer_ctrl_free_pick.sv
// Combinational allocator: lowest buffer index that is neither excluded index.
module mb_free_pick #(
   parameter int unsigned NUM_BUF = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [IDX_W-1:0] i_excl_a,
   input  logic [IDX_W-1:0] i_excl_b,
   output logic [IDX_W-1:0] o_idx
);

   // Scan downwards so the last hit, the lowest free index, wins.
   always_comb begin
      o_idx = '0;
      for (int i = int'(NUM_BUF) - 1; i >= 0; i--) begin
         if ((IDX_W'(i) != i_excl_a) && (IDX_W'(i) != i_excl_b)) begin
            o_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/multi_buffer_ctrl.sv
// N-way frame-buffer swap controller. Writer fills wr_idx while the reader scans
// rd_idx; finished frames are promoted only on frame_sync so the reader never tears.
// Optional build macro SWAP_STATS_EN adds saturating swap/drop counters.
module multi_buffer_ctrl
   import multi_buffer_pkg::*;
#(
   parameter int unsigned NUM_BUF = 2,
   parameter int unsigned Y_W     = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   multi_buffer_ctrl_if.slave   bus
`ifdef SWAP_STATS_EN
   ,
   output logic [15:0]          swap_cnt,
   output logic [15:0]          drop_cnt
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_BUF);

   if (NUM_BUF < 2 || NUM_BUF > MAX_BUF) begin : g_bad_num_buf
      $error("multi_buffer_ctrl: NUM_BUF must be 2..%0d", MAX_BUF);
   end

   state_e             r_state, w_state_d;
   logic [IDX_W-1:0]   r_rd_idx, w_rd_idx_d;
   logic [IDX_W-1:0]   r_wr_idx, w_wr_idx_d;
   logic [IDX_W-1:0]   r_ready_idx, w_ready_idx_d;
   logic               r_ready_v, w_ready_v_d;
   logic [NUM_BUF-1:0] r_wr_en;
   logic [NUM_BUF-1:0] r_rd_en;
   logic [Y_W-1:0]     r_wr_y;
   logic               w_stall;
   logic               w_wr_accept;
   logic [IDX_W-1:0]   w_pick_a;
   logic [IDX_W-1:0]   w_pick;

   assign w_stall     = (r_state == StWait);
   assign w_wr_accept = bus.wr_valid && !w_stall;

   // New write buffer must avoid the (possibly new) read buffer and any ready frame.
   // On a swap/direct promotion the completing wr_idx becomes rd_idx, so exclude it twice.
   assign w_pick_a = ((NUM_BUF == 2) || bus.frame_sync) ? r_wr_idx : r_rd_idx;

   mb_free_pick #(
      .NUM_BUF (NUM_BUF),
      .IDX_W   (IDX_W)
   ) u_free_pick (
      .i_excl_a (w_pick_a),
      .i_excl_b (r_wr_idx),
      .o_idx    (w_pick)
   );

   // Next-state: buffer rotation and WRITE/WAIT control.
   always_comb begin
      w_state_d     = r_state;
      w_rd_idx_d    = r_rd_idx;
      w_wr_idx_d    = r_wr_idx;
      w_ready_idx_d = r_ready_idx;
      w_ready_v_d   = r_ready_v;
      if (NUM_BUF == 2) begin
         unique case (r_state)
            StWrite: begin
               if (bus.wr_done) w_state_d = StWait;
            end
            StWait: begin
               if (bus.frame_sync) begin
                  w_rd_idx_d = r_wr_idx;
                  w_wr_idx_d = w_pick;
                  w_state_d  = StWrite;
               end
            end
            default: w_state_d = StWrite;
         endcase
      end else begin
         w_state_d = StWrite;
         if (bus.wr_done && bus.frame_sync) begin
            // Completing frame goes straight to the reader; any older ready frame is dropped.
            w_rd_idx_d  = r_wr_idx;
            w_wr_idx_d  = w_pick;
            w_ready_v_d = 1'b0;
         end else if (bus.wr_done) begin
            w_ready_idx_d = r_wr_idx;
            w_ready_v_d   = 1'b1;
            w_wr_idx_d    = w_pick;
         end else if (bus.frame_sync && r_ready_v) begin
            w_rd_idx_d  = r_ready_idx;
            w_ready_v_d = 1'b0;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= StWrite;
         r_rd_idx    <= '0;
         r_wr_idx    <= IDX_W'(1);
         r_ready_idx <= '0;
         r_ready_v   <= 1'b0;
         r_wr_en     <= '0;
         r_rd_en     <= NUM_BUF'(1);
         r_wr_y      <= '0;
      end else begin
         r_state     <= w_state_d;
         r_rd_idx    <= w_rd_idx_d;
         r_wr_idx    <= w_wr_idx_d;
         r_ready_idx <= w_ready_idx_d;
         r_ready_v   <= w_ready_v_d;
         // Write uses the pre-update wr_idx so data on the wr_done cycle lands in the old buffer.
         r_wr_en     <= w_wr_accept ? NUM_BUF'(onehot(32'(r_wr_idx))) : '0;
         r_rd_en     <= NUM_BUF'(onehot(32'(w_rd_idx_d)));
         if (w_wr_accept) r_wr_y <= bus.y;
      end
   end

   assign bus.wr_en    = r_wr_en;
   assign bus.rd_en    = r_rd_en;
   assign bus.wr_y     = r_wr_y;
   assign bus.wr_stall = w_stall;
   assign bus.wr_idx   = r_wr_idx;
   assign bus.rd_idx   = r_rd_idx;

`ifdef SWAP_STATS_EN
   logic [15:0] r_swap_cnt;
   logic [15:0] r_drop_cnt;
   logic        w_swap_inc;
   logic        w_drop_inc;

   // Event decode for the statistics counters.
   always_comb begin
      w_swap_inc = (w_rd_idx_d != r_rd_idx);
      if (NUM_BUF == 2) w_drop_inc = w_stall && bus.wr_done;
      else              w_drop_inc = bus.wr_done && r_ready_v;
   end

   // Saturating counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_swap_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_swap_inc && (r_swap_cnt != 16'hFFFF)) r_swap_cnt <= r_swap_cnt + 16'd1;
         if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign swap_cnt = r_swap_cnt;
   assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_multi_buffer_ctrl.sv
// Directed bench for multi_buffer_ctrl: a 2-buffer and a 3-buffer instance side by side.
module tb_multi_buffer_ctrl;

   logic clk;
   logic resetn;
   int   n_assert;
   int   n_fail;

   multi_buffer_ctrl_if #(.NUM_BUF(2), .Y_W(8)) bus2 ();
   multi_buffer_ctrl_if #(.NUM_BUF(3), .Y_W(8)) bus3 ();

`ifdef SWAP_STATS_EN
   logic [15:0] swap2, drop2, swap3, drop3;
`endif

   multi_buffer_ctrl #(.NUM_BUF(2), .Y_W(8)) dut2 (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus2.slave)
`ifdef SWAP_STATS_EN
      ,
      .swap_cnt (swap2),
      .drop_cnt (drop2)
`endif
   );

   multi_buffer_ctrl #(.NUM_BUF(3), .Y_W(8)) dut3 (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus3.slave)
`ifdef SWAP_STATS_EN
      ,
      .swap_cnt (swap3),
      .drop_cnt (drop3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      bus2.y = '0; bus2.wr_valid = 1'b0; bus2.wr_done = 1'b0; bus2.frame_sync = 1'b0;
      bus3.y = '0; bus3.wr_valid = 1'b0; bus3.wr_done = 1'b0; bus3.frame_sync = 1'b0;
      step();
      step();

      // Reset state
      chk("rst2_rd_en",  32'(bus2.rd_en),    32'h1);
      chk("rst2_wr_idx", 32'(bus2.wr_idx),   32'h1);
      chk("rst2_rd_idx", 32'(bus2.rd_idx),   32'h0);
      chk("rst2_wr_en",  32'(bus2.wr_en),    32'h0);
      chk("rst2_wr_y",   32'(bus2.wr_y),     32'h0);
      chk("rst2_stall",  32'(bus2.wr_stall), 32'h0);
      chk("rst3_rd_en",  32'(bus3.rd_en),    32'h1);
      chk("rst3_wr_idx", 32'(bus3.wr_idx),   32'h1);

      // 2-buf write latency
      resetn = 1'b1;
      bus2.y = 8'h2A; bus2.wr_valid = 1'b1;
      step();
      chk("w2_wr_en", 32'(bus2.wr_en), 32'h2);
      chk("w2_wr_y",  32'(bus2.wr_y),  32'h2A);
      bus2.wr_valid = 1'b0;
      step();
      chk("w2_idle_wr_en", 32'(bus2.wr_en), 32'h0);
      chk("w2_hold_wr_y",  32'(bus2.wr_y),  32'h2A);

      // frame_sync in WRITE does nothing
      bus2.frame_sync = 1'b1;
      step();
      bus2.frame_sync = 1'b0;
      chk("fs_write_rd_idx", 32'(bus2.rd_idx),   32'h0);
      chk("fs_write_stall",  32'(bus2.wr_stall), 32'h0);

      // wr_done with a same-cycle write goes to the old buffer, then stall
      bus2.wr_done = 1'b1; bus2.wr_valid = 1'b1; bus2.y = 8'h55;
      step();
      bus2.wr_done = 1'b0; bus2.y = 8'h77;
      chk("done2_wr_en", 32'(bus2.wr_en),    32'h2);
      chk("done2_wr_y",  32'(bus2.wr_y),     32'h55);
      chk("done2_stall", 32'(bus2.wr_stall), 32'h1);
      step();
      bus2.wr_valid = 1'b0;
      chk("stall2_wr_en", 32'(bus2.wr_en), 32'h0);
      chk("stall2_wr_y",  32'(bus2.wr_y),  32'h55);
      bus2.frame_sync = 1'b1;
      step();
      bus2.frame_sync = 1'b0;
      chk("swap2_rd_idx", 32'(bus2.rd_idx),   32'h1);
      chk("swap2_wr_idx", 32'(bus2.wr_idx),   32'h0);
      chk("swap2_rd_en",  32'(bus2.rd_en),    32'h2);
      chk("swap2_stall",  32'(bus2.wr_stall), 32'h0);

      // Simultaneous wr_done & frame_sync: WAIT only, swap on a later sync
      bus2.wr_done = 1'b1; bus2.frame_sync = 1'b1;
      step();
      bus2.frame_sync = 1'b0;
      chk("sim2_stall",  32'(bus2.wr_stall), 32'h1);
      chk("sim2_rd_idx", 32'(bus2.rd_idx),   32'h1);
      // wr_done again while waiting (counted as a drop)
      step();
      bus2.wr_done = 1'b0;
      bus2.frame_sync = 1'b1;
      step();
      bus2.frame_sync = 1'b0;
      chk("sim2_swap_rd_idx", 32'(bus2.rd_idx), 32'h0);
      chk("sim2_swap_wr_idx", 32'(bus2.wr_idx), 32'h1);
      chk("sim2_swap_rd_en",  32'(bus2.rd_en),  32'h1);
`ifdef SWAP_STATS_EN
      chk("stats2_swap", 32'(swap2), 32'h2);
      chk("stats2_drop", 32'(drop2), 32'h1);
`endif

      // Reset mid-WAIT with an in-flight write
      bus2.wr_done = 1'b1;
      step();
      bus2.wr_done = 1'b0;
      chk("pre_rst_stall", 32'(bus2.wr_stall), 32'h1);
      resetn = 1'b0; bus2.wr_valid = 1'b1; bus2.y = 8'hEE;
      step();
      bus2.wr_valid = 1'b0;
      chk("mid_rst_stall",  32'(bus2.wr_stall), 32'h0);
      chk("mid_rst_wr_en",  32'(bus2.wr_en),    32'h0);
      chk("mid_rst_wr_y",   32'(bus2.wr_y),     32'h0);
      chk("mid_rst_rd_en",  32'(bus2.rd_en),    32'h1);
      chk("mid_rst_rd_idx", 32'(bus2.rd_idx),   32'h0);
      chk("mid_rst_wr_idx", 32'(bus2.wr_idx),   32'h1);
`ifdef SWAP_STATS_EN
      chk("mid_rst_swap", 32'(swap2), 32'h0);
      chk("mid_rst_drop", 32'(drop2), 32'h0);
`endif
      resetn = 1'b1;

      // 3-buf: frame_sync with nothing ready
      bus3.frame_sync = 1'b1;
      step();
      bus3.frame_sync = 1'b0;
      chk("empty3_rd_idx", 32'(bus3.rd_idx), 32'h0);
      chk("empty3_wr_idx", 32'(bus3.wr_idx), 32'h1);
`ifdef SWAP_STATS_EN
      chk("empty3_swap", 32'(swap3), 32'h0);
`endif

      // 3-buf: two frames done, the older is discarded, then sync
      bus3.wr_done = 1'b1;
      step();
      chk("done3a_wr_idx", 32'(bus3.wr_idx), 32'h2);
      chk("done3a_stall",  32'(bus3.wr_stall), 32'h0);
      step();
      bus3.wr_done = 1'b0;
      chk("done3b_wr_idx", 32'(bus3.wr_idx), 32'h1);
      bus3.frame_sync = 1'b1;
      step();
      bus3.frame_sync = 1'b0;
      chk("sync3_rd_idx", 32'(bus3.rd_idx), 32'h2);
      chk("sync3_wr_idx", 32'(bus3.wr_idx), 32'h1);
      chk("sync3_rd_en",  32'(bus3.rd_en),  32'h4);
`ifdef SWAP_STATS_EN
      chk("sync3_drop", 32'(drop3), 32'h1);
      chk("sync3_swap", 32'(swap3), 32'h1);
`endif

      // 3-buf: wr_done & frame_sync together from reset
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      bus3.wr_done = 1'b1; bus3.frame_sync = 1'b1;
      step();
      bus3.wr_done = 1'b0; bus3.frame_sync = 1'b0;
      chk("sim3_rd_idx",  32'(bus3.rd_idx),     32'h1);
      chk("sim3_wr_idx",  32'(bus3.wr_idx),     32'h0);
      chk("sim3_ready_v", 32'(dut3.r_ready_v),  32'h0);
      chk("sim3_rd_en",   32'(bus3.rd_en),      32'h2);
      bus3.frame_sync = 1'b1; bus3.wr_valid = 1'b1; bus3.y = 8'h3C;
      step();
      bus3.frame_sync = 1'b0; bus3.wr_valid = 1'b0;
      chk("hold3_rd_idx", 32'(bus3.rd_idx), 32'h1);
      chk("w3_wr_en",     32'(bus3.wr_en),  32'h1);
      chk("w3_wr_y",      32'(bus3.wr_y),   32'h3C);
`ifdef SWAP_STATS_EN
      chk("hold3_swap", 32'(swap3), 32'h1);
`endif

      // Random run: buffer-ownership invariants
      for (int i = 0; i < 400; i++) begin
         bus2.wr_valid   = 1'($urandom_range(0, 1));
         bus2.y          = 8'($urandom_range(0, 255));
         bus2.wr_done    = ($urandom_range(0, 3) == 0);
         bus2.frame_sync = ($urandom_range(0, 3) == 0);
         bus3.wr_valid   = 1'($urandom_range(0, 1));
         bus3.y          = 8'($urandom_range(0, 255));
         bus3.wr_done    = ($urandom_range(0, 3) == 0);
         bus3.frame_sync = ($urandom_range(0, 3) == 0);
         step();
         n_assert++;
         assert (bus2.wr_idx !== bus2.rd_idx)
         else begin
            n_fail++;
            $error("FAIL inv2_idx: wr_idx %0d rd_idx %0d required distinct", bus2.wr_idx,
                   bus2.rd_idx);
         end
         n_assert++;
         assert ((bus3.wr_idx !== bus3.rd_idx) && (bus3.rd_idx < 2'd3) && (bus3.wr_idx < 2'd3))
         else begin
            n_fail++;
            $error("FAIL inv3_idx: wr_idx %0d rd_idx %0d required distinct and < 3",
                   bus3.wr_idx, bus3.rd_idx);
         end
         n_assert++;
         assert (!dut3.r_ready_v || ((dut3.r_ready_idx !== bus3.wr_idx) &&
                                     (dut3.r_ready_idx !== bus3.rd_idx)))
         else begin
            n_fail++;
            $error("FAIL inv3_ready: ready_idx %0d wr_idx %0d rd_idx %0d required distinct",
                   dut3.r_ready_idx, bus3.wr_idx, bus3.rd_idx);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
